// File: rtl/mov8_sequencer.sv
// MOV8 register-transfer sequencer: drives one-hot source select and destination
// load strobes for a 00DDDSSS move, with settle / load / hold phases.
//   state  | meaning
//   IDLE   | waiting for start
//   SEL    | source drives the bus, SETTLE cycles
//   LOAD   | destination strobe high, LOAD_W cycles
//   HOLD   | bus held one cycle past the strobe
//   DONE   | one-cycle completion pulse, may accept the next start
module mov8_sequencer #(
  parameter int SETTLE = 2,
  parameter int LOAD_W = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  output logic [7:0] sel,
  output logic [7:0] ld,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_LOAD, S_HOLD, S_DONE} state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [3:0] LOAD_M1   = 4'(LOAD_W - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  instr_q, instr_d;
  logic [7:0]  sel_q, sel_d, ld_q, ld_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [2:0]  src, dst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        if (start) begin
          if (instr[7:6] == 2'b00) begin
            state_d = S_SEL;
            instr_d = instr[5:0];
            cnt_d   = SETTLE_M1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SEL: begin
        if (cnt_q == 4'd0) begin
          state_d = S_LOAD;
          cnt_d   = LOAD_M1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_LOAD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_DONE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they come straight out of flops.
  always_comb begin
    src    = instr_d[2:0];
    dst    = instr_d[5:3];
    busy_d = (state_d == S_SEL) || (state_d == S_LOAD) || (state_d == S_HOLD);
    sel_d  = (busy_d && (src != dst)) ? (8'b1 << src) : 8'h00;
    ld_d   = (state_d == S_LOAD) ? (8'b1 << dst) : 8'h00;
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      instr_q <= 6'd0;
      sel_q   <= 8'h00;
      ld_q    <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      sel_q   <= sel_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sel  = sel_q;
  assign ld   = ld_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_mov8_sequencer.sv
// Scoreboard bench for mov8_sequencer: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares whenever a DUT output is active.
module tb_mov8_sequencer;

  logic       clk = 1'b0;
  logic       rst0, rst1, start0, start1;
  logic [7:0] instr0, instr1;
  logic [7:0] sel0, ld0, sel1, ld1;
  logic       busy0, done0, err0, busy1, done1, err1;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    logic [7:0] sel;
    logic [7:0] ld;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  mov8_sequencer dut0 (
    .clk(clk), .reset(rst0), .start(start0), .instr(instr0),
    .sel(sel0), .ld(ld0), .busy(busy0), .done(done0), .err(err0)
  );

  mov8_sequencer #(.SETTLE(4), .LOAD_W(3)) dut1 (
    .clk(clk), .reset(rst1), .start(start1), .instr(instr1),
    .sel(sel1), .ld(ld1), .busy(busy1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic push(input int which, input exp_t e);
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Expected trace of one transfer whose first SEL cycle is at cycle a.
  task automatic push_xfer(input int which, input int a, input logic [7:0] s,
                           input logic [7:0] l, input int settle, input int loadw);
    int c;
    c = a;
    for (int k = 0; k < settle; k++) begin
      push(which, '{c, s, 8'h00, 1'b1, 1'b0, 1'b0}); c++;
    end
    for (int k = 0; k < loadw; k++) begin
      push(which, '{c, s, l, 1'b1, 1'b0, 1'b0}); c++;
    end
    push(which, '{c, s, 8'h00, 1'b1, 1'b0, 1'b0}); c++;
    push(which, '{c, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_dut(input int which, input logic [7:0] s, input logic [7:0] l,
                           input logic b, input logic d, input logic e);
    exp_t x;
    if (s == 8'h00 && l == 8'h00 && !b && !d && !e) return;
    n_cmp++;
    if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
      n_bad++;
      $display("FAIL unexpected_output dut%0d cyc=%0d got sel=%h ld=%h busy=%b done=%b err=%b required all idle",
               which, cyc, s, l, b, d, e);
      return;
    end
    if (which == 0) x = q0.pop_front();
    else x = q1.pop_front();
    if (x.cyc != cyc || x.sel !== s || x.ld !== l || x.busy !== b || x.done !== d || x.err !== e) begin
      n_bad++;
      $display("FAIL trace dut%0d: got cyc=%0d sel=%h ld=%h busy=%b done=%b err=%b required cyc=%0d sel=%h ld=%h busy=%b done=%b err=%b",
               which, cyc, s, l, b, d, e, x.cyc, x.sel, x.ld, x.busy, x.done, x.err);
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, sel0, ld0, busy0, done0, err0);
    check_dut(1, sel1, ld1, busy1, done1, err1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int t;
    rst0 = 1'b1; rst1 = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    instr0 = 8'h00; instr1 = 8'h00;
    repeat (2) @(negedge clk);
    // start during reset must not be accepted
    start0 = 1'b1; instr0 = 8'h01;
    @(negedge clk);
    chk("reset_sel", sel0, 8'h00);
    chk("reset_ld", ld0, 8'h00);
    chk("reset_flags", {5'b0, busy0, done0, err0}, 8'h00);
    start0 = 1'b0;
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    // A<-B
    a = cyc + 1;
    push_xfer(0, a, 8'h02, 8'h01, 2, 1);
    start0 = 1'b1; instr0 = 8'h01;
    @(negedge clk); start0 = 1'b0;
    repeat (6) @(negedge clk);

    // Y<-Y clear: no select, strobe still fires
    a = cyc + 1;
    push_xfer(0, a, 8'h00, 8'h80, 2, 1);
    start0 = 1'b1; instr0 = 8'h3F;
    @(negedge clk); start0 = 1'b0;
    repeat (6) @(negedge clk);

    // illegal opcode then B<-A
    a = cyc + 1;
    push(0, '{a, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1});
    start0 = 1'b1; instr0 = 8'h81;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk);
    a = cyc + 1;
    push_xfer(0, a, 8'h01, 8'h02, 2, 1);
    start0 = 1'b1; instr0 = 8'h08;
    @(negedge clk); start0 = 1'b0;
    repeat (6) @(negedge clk);

    // C<-A with start held, instr changed mid-transfer, back-to-back D<-Y
    a = cyc + 1;
    push_xfer(0, a, 8'h01, 8'h04, 2, 1);
    push_xfer(0, a + 5, 8'h80, 8'h08, 2, 1);
    start0 = 1'b1; instr0 = 8'h10;
    @(negedge clk);
    @(negedge clk); instr0 = 8'h1F;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk);
    @(negedge clk); start0 = 1'b0;
    repeat (6) @(negedge clk);

    // async reset during LOAD of A<-B
    a = cyc + 1;
    push(0, '{a,     8'h02, 8'h00, 1'b1, 1'b0, 1'b0});
    push(0, '{a + 1, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0});
    start0 = 1'b1; instr0 = 8'h01;
    @(posedge clk); #1 start0 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_reset_ld", ld0, 8'h01);
    #1 rst0 = 1'b1;
    #1;
    chk("async_reset_ld", ld0, 8'h00);
    chk("async_reset_sel", sel0, 8'h00);
    chk("async_reset_busy", {7'b0, busy0}, 8'h00);
    repeat (3) @(negedge clk);
    chk("reset_no_done", {7'b0, done0}, 8'h00);
    rst0 = 1'b0;
    @(negedge clk);
    a = cyc + 1;
    push_xfer(0, a, 8'h01, 8'h02, 2, 1);
    start0 = 1'b1; instr0 = 8'h08;
    @(negedge clk); start0 = 1'b0;
    repeat (6) @(negedge clk);

    // SETTLE=4, LOAD_W=3: X<-Y (0x37)
    a = cyc + 1;
    push_xfer(1, a, 8'h80, 8'h40, 4, 3);
    start1 = 1'b1; instr1 = 8'h37;
    @(negedge clk); start1 = 1'b0;
    repeat (10) @(negedge clk);

    // 0x2E encodes M2<-X
    a = cyc + 1;
    push_xfer(1, a, 8'h40, 8'h20, 4, 3);
    start1 = 1'b1; instr1 = 8'h2E;
    @(negedge clk); start1 = 1'b0;
    repeat (10) @(negedge clk);

    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL missing_outputs: got %0d/%0d expectations left required 0/0",
               q0.size(), q1.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
